byte_packer_8_to_32: RTL and testbench

- Downstream companion of the 32-bit to 4x8 serializer.
- Collects the 8-bit byte stream and reassembles 32-bit words, lane order least-significant byte first: byte 0 goes to [7:0] and byte 3 to [31:24].
- Adds valid/ready handshakes on both sides, a small output word FIFO for backpressure, and start-of-word resynchronisation.

---
 rtl/byte_packer_8_to_32.sv | 145 ++++++++++++++
 tb/tb_byte_packer_8_to_32.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_packer_8_to_32.sv
`default_nettype none
// ============================================================================
//  Module   : byte_packer_8_to_32
//  Purpose  : Reassembles an 8-bit byte stream into 32-bit words, least-
//             significant byte first (byte 0 -> [7:0], byte 3 -> [31:24]).
//             A small word FIFO absorbs output backpressure, and a
//             start-of-word marker re-aligns the lane counter.
//  Ports    : clock_i      rising-edge clock
//             reset_i      asynchronous, active-high reset
//             in_data_i    incoming byte
//             in_valid_i   in_data_i is valid
//             in_sop_i     byte is lane 0 of a new word (only on accept)
//             in_ready_o   packer can accept a byte this cycle
//             out_data_o   head word of the FIFO
//             out_valid_o  out_data_o holds a complete word
//             out_ready_i  consumer takes out_data_o this cycle
//             align_err_o  one-cycle pulse: partial word dropped by in_sop_i
//             word_cnt_o   words delivered (popped), wrapping
//  Revision : 1.0 - initial release
// ============================================================================
module byte_packer_8_to_32 #(
  parameter int DEPTH = 2,   // FIFO entries, power of two, >= 2
  parameter int CNT_W = 16   // delivered-word counter width
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [7:0]       in_data_i,
  input  logic             in_valid_i,
  input  logic             in_sop_i,
  output logic             in_ready_o,
  output logic [31:0]      out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             align_err_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH) + 1;
  localparam logic [FW-1:0] C_DEPTH = FW'(DEPTH);

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_e;

  lane_e             lane_q, lane_d;
  logic [23:0]       asm_q, asm_d;      // lanes 0..2; lane 3 goes straight to the FIFO
  logic [31:0]       mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              align_err_q, align_err_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  logic w_accept;
  logic w_pop;
  logic w_resync;
  logic w_push;

  assign w_accept = in_valid_i && in_ready_q;
  assign w_pop    = out_valid_q && out_ready_i;
  // A start-of-word marker on anything but lane 0 throws away the partial word.
  assign w_resync = w_accept && in_sop_i && (lane_q != LANE0);
  assign w_push   = w_accept && !w_resync && (lane_q == LANE3);

  always_comb begin
    lane_d      = lane_q;
    asm_d       = asm_q;
    align_err_d = 1'b0;

    if (w_resync) begin
      asm_d[7:0]  = in_data_i;
      lane_d      = LANE1;
      align_err_d = 1'b1;
    end else if (w_accept) begin
      case (lane_q)
        LANE0: begin asm_d[7:0]   = in_data_i; lane_d = LANE1; end
        LANE1: begin asm_d[15:8]  = in_data_i; lane_d = LANE2; end
        LANE2: begin asm_d[23:16] = in_data_i; lane_d = LANE3; end
        LANE3: begin lane_d = LANE0; end
        default: lane_d = LANE0;
      endcase
    end

    // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH for free.
    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({w_push, w_pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    word_cnt_d = w_pop ? word_cnt_q + 1'b1 : word_cnt_q;

    // Handshake outputs are computed from next state and registered, so
    // in_ready_o never depends combinationally on out_ready_i.
    out_valid_d = (fill_d != '0);
    in_ready_d  = (lane_d != LANE3) || (fill_d < C_DEPTH);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      lane_q      <= LANE0;
      asm_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      align_err_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      if (w_push) begin
        mem_q[wr_ptr_q] <= {in_data_i, asm_q};
      end
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      align_err_q <= align_err_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign align_err_o = align_err_q;
  assign word_cnt_o  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_packer_8_to_32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_packer_8_to_32
//  Purpose  : Scoreboard bench for byte_packer_8_to_32. A byte-level model
//             collects accepted bytes into a list and queues each finished
//             word; a monitor compares DUT outputs against that queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_byte_packer_8_to_32;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;   // narrow counter so wrap-around is reachable

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_sop = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             align_err;
  logic [CNT_W-1:0] word_cnt;

  byte_packer_8_to_32 #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_sop_i    (in_sop),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .align_err_o (align_err),
    .word_cnt_o  (word_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [31:0] exp_q[$];   // words that should be sitting in the FIFO
  logic [7:0]  part[$];    // bytes of the word being assembled
  int          pops = 0;
  bit          align_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  // Monitor: outputs are stable at the falling edge; compare, then apply the
  // handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      part.delete();
      pops      = 0;
      align_exp = 1'b0;
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
      chk("in_ready", {31'd0, in_ready},
          {31'd0, !(part.size() == 3 && exp_q.size() >= DEPTH)});
      chk("align_err", {31'd0, align_err}, {31'd0, align_exp});
      chk("word_cnt", 32'(word_cnt), 32'(pops % (1 << CNT_W)));
      align_exp = 1'b0;
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (in_valid && in_ready) begin
        if (in_sop && part.size() != 0) begin
          part.delete();
          align_exp = 1'b1;
        end
        part.push_back(in_data);
        if (part.size() == 4) begin
          exp_q.push_back({part[3], part[2], part[1], part[0]});
          part.delete();
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      $display("FAIL accept_timeout: actual=no-accept required=accept at %0t", $time);
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit sop);
    in_data  = b;
    in_sop   = sop;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int l = 0; l < 4; l++) send(t[8*l +: 8], l == 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"},  out_data, 32'd0);
    chk({tag, "_in_ready"},  {31'd0, in_ready}, 32'd1);
    chk({tag, "_align_err"}, {31'd0, align_err}, 32'd0);
    chk({tag, "_word_cnt"},  32'(word_cnt), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    // Power-on reset
    #2 rst = 1'b1;
    #1 reset_checks("por");
    cyc(); cyc();
    rst = 1'b0;

    // Basic packing
    out_ready = 1'b1;
    send(8'h11, 1'b1); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    repeat (3) cyc();

    // Backpressure: 11 bytes fit, the 12th waits for a pop
    out_ready = 1'b0;
    for (int b = 0; b < 11; b++) send(8'(b), (b % 4) == 0);
    in_data  = 8'h0B;
    in_valid = 1'b1;
    repeat (4) cyc();
    out_ready = 1'b1;
    wait_accept();
    repeat (6) cyc();

    // Resync mid-word
    send(8'hAA, 1'b1); send(8'hBB, 1'b0);
    send(8'h01, 1'b1); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    repeat (4) cyc();

    // Continuous stream with simultaneous push/pop
    for (int i = 0; i < 40; i++) send(8'($urandom), (i % 4) == 0);
    repeat (4) cyc();

    // Asynchronous reset with a buffered word and a partial word
    out_ready = 1'b0;
    send_word(32'hCAFE_F00D);
    send(8'h55, 1'b1); send(8'h66, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 reset_checks("midrst");
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    send(8'hA1, 1'b0); send(8'hB2, 1'b0); send(8'hC3, 1'b0); send(8'hD4, 1'b0);
    repeat (4) cyc();

    // Round trip from a serializer with fixed 4-byte phase
    send_word(32'hDEAD_BEEF);
    send_word(32'h0123_4567);
    repeat (4) cyc();

    // Randomized traffic with random backpressure and stray sop markers
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_sop    = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 4) != 0);
      cyc();
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;

    // Long serializer run to carry word_cnt past its wrap point
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) send_word($urandom);
    repeat (8) cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
